// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the architectural PC, issues
//               sequential word fetches to instruction memory, accepts
//               redirects from the jump-target stage, buffers returned
//               instructions in a small in-order queue and hands
//               {pc, instr} pairs to decode over a valid/ready handshake.
//               Responses belonging to fetches issued before a redirect are
//               counted in a kill counter and silently discarded.
//
// Ports       :
//   clk            in   1   clock, rising edge
//   rst_n          in   1   synchronous reset, active low
//   redirect_valid in   1   taken control transfer this cycle
//   redirect_pc    in  32   new PC (bits [1:0] ignored)
//   imem_req       out  1   fetch request valid
//   imem_addr      out 32   word-aligned fetch address
//   imem_gnt       in   1   memory accepts the request this cycle
//   imem_rvalid    in   1   read data valid (in order, >=1 cycle after grant)
//   imem_rdata     in  32   instruction word
//   if_valid       out  1   queue head valid toward decode
//   if_ready       in   1   decode accepts head
//   if_pc          out 32   PC of head instruction
//   if_instr       out 32   head instruction
//
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    // outstanding + occupancy + kill each fit in c_cnt_w bits; two extra
    // bits keep their sum from overflowing before the credit compare.
    localparam int c_sum_w = c_cnt_w + 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        r_pc;
    logic [c_cnt_w-1:0] r_outstanding;   // live requests granted, not returned
    logic [c_cnt_w-1:0] r_kill;          // wrong-path responses still to drop

    // In-flight PC FIFO: one entry per granted request (live or killed),
    // popped by every response so the head always matches imem_rdata.
    logic [31:0]        r_fl_pc [DEPTH];
    logic [c_ptr_w-1:0] r_fl_wr;
    logic [c_ptr_w-1:0] r_fl_rd;

    // Instruction queue toward decode
    logic [31:0]        r_q_pc    [DEPTH];
    logic [31:0]        r_q_instr [DEPTH];
    logic [c_ptr_w-1:0] r_q_wr;
    logic [c_ptr_w-1:0] r_q_rd;
    logic [c_cnt_w-1:0] r_q_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_sum_w-1:0] w_sum;
    logic               w_credit;
    logic               w_grant;
    logic               w_resp_live;
    logic               w_resp_killed;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_out_upd;
    logic [c_cnt_w-1:0] w_kill_upd;

    // Credit uses registered counts only, so neither if_ready nor
    // imem_rvalid can reach imem_req combinationally.
    assign w_sum    = c_sum_w'(r_outstanding) + c_sum_w'(r_q_count) + c_sum_w'(r_kill);
    assign w_credit = (w_sum < c_sum_w'(DEPTH));

    // Request is suppressed during a redirect so a grant can never pair
    // with a PC that is about to be replaced.
    assign imem_req  = rst_n & ~redirect_valid & w_credit;
    assign imem_addr = r_pc;

    assign w_grant       = imem_req & imem_gnt;
    // Killed responses are always older than live ones (in-order memory),
    // so the kill counter is drained first.
    assign w_resp_killed = imem_rvalid & (r_kill != '0);
    assign w_resp_live   = imem_rvalid & (r_kill == '0);
    // A live response coinciding with a redirect is wrong-path as well.
    assign w_push        = w_resp_live & ~redirect_valid;
    assign w_pop         = if_valid & if_ready;

    // Counts after this cycle's grant/response, before any redirect fold.
    assign w_out_upd  = r_outstanding + c_cnt_w'(w_grant) - c_cnt_w'(w_resp_live);
    assign w_kill_upd = r_kill - c_cnt_w'(w_resp_killed);

    // ------------------------------------------------------------------
    // Outputs toward decode come straight from queue storage
    // ------------------------------------------------------------------
    assign if_valid = (r_q_count != '0);
    assign if_pc    = r_q_pc[r_q_rd];
    assign if_instr = r_q_instr[r_q_rd];

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_kill        <= '0;
            r_fl_wr       <= '0;
            r_fl_rd       <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_q_count     <= '0;
            // Storage is cleared so if_pc/if_instr read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_fl_pc[i]   <= '0;
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else begin
            // In-flight FIFO tracks every request, independent of redirects.
            if (w_grant) begin
                r_fl_pc[r_fl_wr] <= r_pc;
                r_fl_wr          <= r_fl_wr + c_ptr_w'(1);
            end
            if (imem_rvalid) begin
                r_fl_rd <= r_fl_rd + c_ptr_w'(1);
            end

            if (redirect_valid) begin
                r_pc          <= redirect_pc & ~32'h3;
                // Everything still live becomes wrong-path.
                r_kill        <= w_kill_upd + w_out_upd;
                r_outstanding <= '0;
                // Flush: empty the queue, any same-cycle pop is moot.
                r_q_rd        <= r_q_wr;
                r_q_count     <= '0;
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + 32'd4;
                end
                r_kill        <= w_kill_upd;
                r_outstanding <= w_out_upd;

                if (w_push) begin
                    r_q_pc[r_q_wr]    <= r_fl_pc[r_fl_rd];
                    r_q_instr[r_q_wr] <= imem_rdata;
                    r_q_wr            <= r_q_wr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + c_ptr_w'(1);
                end
                r_q_count <= r_q_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            // Credit accounting guarantees a free slot for every live response.
            assert (!(w_push && (r_q_count == c_cnt_w'(DEPTH))));
            // A response with nothing in flight means the memory misbehaved.
            assert (!(imem_rvalid && (r_outstanding == '0) && (r_kill == '0)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Drives randomized and
//               directed stimulus, emulates an in-order instruction memory
//               and compares DUT outputs against a transaction-level model
//               (fetch epochs, an expected delivery queue and a pending
//               memory queue).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam int          C_DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (C_RESET_PC),
        .DEPTH    (C_DEPTH)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready_cyc;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    flight_t     mem_q[$];      // granted fetches awaiting their response
    item_t       exp_q[$];      // what decode should see, in order
    logic [31:0] grant_log[$];  // DUT addresses actually granted
    logic [31:0] deliv_log[$];  // DUT pcs actually handed to decode
    logic [31:0] m_pc;
    int          epoch;
    int          cyc;
    int          first_valid_cyc;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rvalid_pct = 100;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle. Entered at posedge+1, leaves at the next posedge+1.
    task automatic step(input logic redir, input logic [31:0] tgt,
                        input logic gnt, input logic rdy);
        logic    rv;
        logic    exp_req;
        logic    grant;
        flight_t f;
        item_t   it;

        rv = (mem_q.size() != 0) && (cyc >= mem_q[0].ready_cyc) &&
             (int'($urandom_range(99)) < rvalid_pct);
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_gnt       = gnt;
        if_ready       = rdy;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_data(mem_q[0].addr) : $urandom;
        #4;

        // Credit: every unanswered fetch plus every queued item holds a slot.
        exp_req = ((mem_q.size() + exp_q.size()) < C_DEPTH) && !redir;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("if_pc", if_pc, exp_q[0].pc);
            check("if_instr", if_instr, exp_q[0].instr);
        end
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        // Effects of the coming clock edge
        grant = imem_req & gnt;
        if (grant) grant_log.push_back(imem_addr);
        if (redir) begin
            exp_q.delete();
            epoch++;
            m_pc = tgt & ~32'h3;
            if (rv) void'(mem_q.pop_front());
        end else begin
            if (if_valid && rdy) deliv_log.push_back(if_pc);
            if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
            if (rv) begin
                f = mem_q.pop_front();
                // Only fetches from the current epoch reach decode.
                if (f.epoch == epoch) begin
                    it.pc    = f.addr;
                    it.instr = mem_data(f.addr);
                    exp_q.push_back(it);
                end
            end
            if (grant) begin
                f.addr      = m_pc;
                f.epoch     = epoch;
                f.ready_cyc = cyc + int'($urandom_range(lat_max, lat_min));
                mem_q.push_back(f);
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #4;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, C_RESET_PC);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        // Memory shares the reset: nothing from before survives.
        mem_q.delete();
        exp_q.delete();
        grant_log.delete();
        deliv_log.delete();
        m_pc            = C_RESET_PC;
        epoch           = 0;
        cyc             = 0;
        first_valid_cyc = -1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] log_at(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        logic in_range;

        // Streaming out of reset, 1-cycle memory
        lat_min = 1; lat_max = 1; rvalid_pct = 100;
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1);
        check("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd2);
        check("t1_addr0", log_at(grant_log, 0), 32'h0);
        check("t1_addr1", log_at(grant_log, 1), 32'h4);
        check("t1_addr2", log_at(grant_log, 2), 32'h8);
        check("t1_pc0", log_at(deliv_log, 0), 32'h0);
        check("t1_pc1", log_at(deliv_log, 1), 32'h4);

        // Decode stall: grants limited to DEPTH, order kept on release
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t2_stall_grants", 32'(grant_log.size()), 32'(C_DEPTH));
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
        check("t2_pc0", log_at(deliv_log, 0), 32'h0);
        check("t2_pc1", log_at(deliv_log, 1), 32'h4);
        check("t2_pc2", log_at(deliv_log, 2), 32'h8);

        // Redirect with requests outstanding and an item queued
        lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        while (!(mem_q.size() >= 2 && exp_q.size() >= 1) && n < 50) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("t3_setup_reached", 32'(n < 50), 32'd1);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        grant_log.delete();
        deliv_log.delete();
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1);
        check("t3_next_addr", log_at(grant_log, 0), 32'h100);
        check("t3_first_pc", log_at(deliv_log, 0), 32'h100);

        // Redirect coincident with a response, then a second redirect
        lat_min = 1; lat_max = 2;
        do_reset();
        n = 0;
        while (!(mem_q.size() != 0 && cyc >= mem_q[0].ready_cyc && cyc > 2) && n < 50) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("t4_setup_reached", 32'(n < 50), 32'd1);
        step(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        grant_log.delete();
        deliv_log.delete();
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1);
        check("t4_next_addr", log_at(grant_log, 0), 32'h200);
        check("t4_first_pc", log_at(deliv_log, 0), 32'h200);
        in_range = (deliv_log.size() != 0);
        foreach (deliv_log[i])
            if (deliv_log[i] < 32'h200 || deliv_log[i] >= 32'h300) in_range = 1'b0;
        check("t4_only_new_path", 32'(in_range), 32'd1);

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        grant_log.delete();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
        check("t5_wrap0", log_at(grant_log, 0), 32'hFFFF_FFF8);
        check("t5_wrap1", log_at(grant_log, 1), 32'hFFFF_FFFC);
        check("t5_wrap2", log_at(grant_log, 2), 32'h0000_0000);

        // Randomized traffic
        lat_min = 1; lat_max = 4; rvalid_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(15) == 0), $urandom,
                 ($urandom_range(3) != 0), ($urandom_range(2) != 0));
        end

        // Mid-stream reset with traffic in flight
        n = 0;
        while (!(mem_q.size() != 0 && exp_q.size() != 0) && n < 200) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("t6_setup_reached", 32'(n < 200), 32'd1);
        do_reset();
        lat_min = 1; lat_max = 1; rvalid_pct = 100;
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
        check("t6_restart_addr", log_at(grant_log, 0), C_RESET_PC);
        check("t6_restart_pc", log_at(deliv_log, 0), C_RESET_PC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
